// File: rtl/regbank_arbiter_if.sv
// regbank_arbiter_if: requester-side and bank-side signals of regbank_arbiter; req_lock exists only with REGBANK_ARB_LOCK_EN
interface regbank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int NBits = 16,
    parameter int NREGS = 4,
    parameter int SELW  = (NREGS > 1) ? $clog2(NREGS) : 1
);
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     req_funsel;
    logic [SELW*NREQ-1:0]  req_sel;
    logic [NBits*NREQ-1:0] req_data;
`ifdef REGBANK_ARB_LOCK_EN
    logic [NREQ-1:0]       req_lock;
`endif
    logic [NREQ-1:0]       ack;
    logic [1:0]            reg_funsel;
    logic [NREGS-1:0]      reg_e;
    logic [NBits-1:0]      reg_i;
`ifdef REGBANK_ARB_LOCK_EN
    modport master (output req, req_funsel, req_sel, req_data, req_lock, input ack, reg_funsel, reg_e, reg_i);
    modport slave (input req, req_funsel, req_sel, req_data, req_lock, output ack, reg_funsel, reg_e, reg_i);
`else
    modport master (output req, req_funsel, req_sel, req_data, input ack, reg_funsel, reg_e, reg_i);
    modport slave (input req, req_funsel, req_sel, req_data, output ack, reg_funsel, reg_e, reg_i);
`endif
endinterface

// File: rtl/regbank_arbiter.sv
// regbank_arbiter: round-robin issue of requester ops to a funsel/enable register bank; REGBANK_ARB_LOCK_EN adds per-requester locking
module regbank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NBits = 16,
    parameter int NREGS = 4,
    parameter int SELW  = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input logic clk,
    input logic rst,
    regbank_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);
    logic [NREQ-1:0]  ack_q, ack_d;
    logic [1:0]       funsel_q, funsel_d;
    logic [NREGS-1:0] e_q, e_d;
    logic [NBits-1:0] i_q, i_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [NREQ-1:0]  elig;
    logic             found;
    logic [PW-1:0]    win, idx;
    logic [1:0]       fs_w;
    logic [SELW-1:0]  sel_w;
`ifdef REGBANK_ARB_LOCK_EN
    logic             lock_q, lock_d, hold;
    logic [PW-1:0]    own_q, own_d;
`endif
    always_comb begin
        elig = bus.req & ~ack_q;
`ifdef REGBANK_ARB_LOCK_EN
        hold = lock_q & bus.req[own_q] & bus.req_lock[own_q];
        elig = hold ? elig & (NREQ'(1) << own_q) : elig;
`endif
        found = 1'b0;
        win = ptr_q;
        idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = PW'((int'(ptr_q) + k) % NREQ);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win = idx;
            end
        end
    end
    always_comb begin
        fs_w = bus.req_funsel[2*win +: 2];
        sel_w = bus.req_sel[SELW*win +: SELW];
        ack_d = found ? NREQ'(1) << win : '0;
        funsel_d = found ? fs_w : 2'b00;
        i_d = (found && fs_w == 2'b01) ? bus.req_data[NBits*win +: NBits] : '0;
        ptr_d = found ? win : ptr_q;
        e_d = '0;
        // Selects at or beyond NREGS match no bit, so the op is acked but discarded
        for (int j = 0; j < NREGS; j++) e_d[j] = found && (int'(sel_w) == j);
`ifdef REGBANK_ARB_LOCK_EN
        lock_d = hold | (found & bus.req_lock[win]);
        own_d = hold ? own_q : win;
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= '0;
            funsel_q <= 2'b00;
            e_q <= '0;
            i_q <= '0;
            ptr_q <= PW'(NREQ - 1);
`ifdef REGBANK_ARB_LOCK_EN
            lock_q <= 1'b0;
            own_q <= '0;
`endif
        end else begin
            ack_q <= ack_d;
            funsel_q <= funsel_d;
            e_q <= e_d;
            i_q <= i_d;
            ptr_q <= ptr_d;
`ifdef REGBANK_ARB_LOCK_EN
            lock_q <= lock_d;
            own_q <= own_d;
`endif
        end
    end
    assign bus.ack = ack_q;
    assign bus.reg_funsel = funsel_q;
    assign bus.reg_e = e_q;
    assign bus.reg_i = i_q;
endmodule
